// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Holds the TX state encoding and line/data-width constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } tx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam int   UART_MAX_DATA_BITS = 9;

  // Index of the last data bit for the
  // selected word length (8 or 9 bits).
  function automatic logic [3:0] last_bit_idx(
    input logic nine
  );
    return nine ? 4'd8 : 4'd7;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud divisor down-counter, shared by TX and RX paths.
// Ports: clk, reset, load (restart bit), div (clocks/bit), bit_end.
module uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 bit_end
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] w_reload;

  // A divisor of 0 behaves like 1: the
  // counter sits at 0 and every clock ends a bit.
  assign w_reload = (div == '0) ? '0 : div - 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load || (r_cnt == '0)) begin
      r_cnt <= w_reload;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign bit_end = (r_cnt == '0);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit engine draining a registered-read TX FIFO.
// Ports: clk, reset, enable, brd, frame cfg, fifo_data/empty/read, tx, busy, tx_done.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] brd,
  input  logic                 nine_bit,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  input  logic [8:0]           fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_read,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  tx_state_t r_state;
  tx_state_t w_next;

  logic [UART_MAX_DATA_BITS-1:0] r_shift;
  logic [3:0]                    r_bit_cnt;
  logic                          r_par;

  logic                 r_nine;
  logic                 r_pen;
  logic                 r_podd;
  logic                 r_two;
  logic [DIV_WIDTH-1:0] r_brd;

  logic                 w_bit_end;
  logic                 w_load;
  logic [DIV_WIDTH-1:0] w_div;
  logic                 w_last_bit;
  logic                 w_start_ok;
  logic                 w_final_stop;
  logic                 w_next_timed;
  logic                 w_tx;

  assign w_start_ok = enable && !fifo_empty;
  assign w_last_bit = (r_bit_cnt == last_bit_idx(r_nine));

  assign w_final_stop = w_bit_end &&
    (((r_state == STOP1) && !r_two) ||
     (r_state == STOP2));

  // In LOAD the divisor register is being
  // written this same edge, so feed the live
  // input straight to the counter.
  assign w_div = (r_state == LOAD) ? brd : r_brd;

  assign w_next_timed =
    (w_next == START)  ||
    (w_next == DATA)   ||
    (w_next == PARITY) ||
    (w_next == STOP1)  ||
    (w_next == STOP2);

  // Restart the bit timer on every entry into
  // a timed state; between DATA bits the
  // counter wraps on its own.
  assign w_load = w_next_timed && (w_next != r_state);

  uart_baud_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load),
    .div     (w_div),
    .bit_end (w_bit_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_start_ok) w_next = POP;
      end
      POP: begin
        w_next = LOAD;
      end
      LOAD: begin
        w_next = START;
      end
      START: begin
        if (w_bit_end) w_next = DATA;
      end
      DATA: begin
        if (w_bit_end && w_last_bit) begin
          w_next = r_pen ? PARITY : STOP1;
        end
      end
      PARITY: begin
        if (w_bit_end) w_next = STOP1;
      end
      STOP1: begin
        if (w_bit_end) begin
          if (r_two) begin
            w_next = STOP2;
          end else begin
            w_next = w_start_ok ? POP : IDLE;
          end
        end
      end
      STOP2: begin
        if (w_bit_end) begin
          w_next = w_start_ok ? POP : IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_comb begin
    w_tx = UART_IDLE_LEVEL;
    unique case (r_state)
      START:   w_tx = 1'b0;
      DATA:    w_tx = r_shift[0];
      PARITY:  w_tx = r_par ^ r_podd;
      default: w_tx = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par     <= 1'b0;
      r_nine    <= 1'b0;
      r_pen     <= 1'b0;
      r_podd    <= 1'b0;
      r_two     <= 1'b0;
      r_brd     <= '0;
    end else if (r_state == LOAD) begin
      // In 8-bit mode bit 8 is dropped so it can
      // never reach the line or the parity.
      r_shift   <= nine_bit ? fifo_data
                            : {1'b0, fifo_data[7:0]};
      r_bit_cnt <= '0;
      r_par     <= 1'b0;
      r_nine    <= nine_bit;
      r_pen     <= parity_en;
      r_podd    <= parity_odd;
      r_two     <= two_stop;
      r_brd     <= brd;
    end else if ((r_state == DATA) && w_bit_end) begin
      r_shift   <= r_shift >> 1;
      r_par     <= r_par ^ r_shift[0];
      r_bit_cnt <= w_last_bit ? 4'd0
                              : r_bit_cnt + 4'd1;
    end
  end

  assign tx        = w_tx;
  assign fifo_read = (r_state == POP);
  assign busy      = (r_state != IDLE);
  assign tx_done   = w_final_stop;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer.
// Stimulus queues expected frames; a monitor compares captured waveforms.
module tb_uart_tx_serializer;

  typedef struct {
    logic [12:0] bits;
    int          nb;
    int          bt;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] brd;
  logic        nine_bit;
  logic        parity_en;
  logic        parity_odd;
  logic        two_stop;
  logic [8:0]  fifo_data = '0;
  logic        fifo_empty;
  logic        fifo_read;
  logic        tx;
  logic        busy;
  logic        tx_done;

  always #5 clk = ~clk;

  uart_tx_serializer #(.DIV_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .brd        (brd),
    .nine_bit   (nine_bit),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_read  (fifo_read),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  // FIFO model: registered read port.
  logic [8:0] wmem [0:255];
  int n_push = 0;
  int n_pop  = 0;
  int cyc    = 0;

  assign fifo_empty = (n_push == n_pop);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_read && !fifo_empty) begin
      fifo_data <= wmem[n_pop % 256];
      n_pop     <= n_pop + 1;
    end
  end

  frame_t expq[$];
  int nchk = 0;
  int nerr = 0;

  task automatic chk(string name, int act, int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Reference: frame as a list of line levels.
  function automatic frame_t mk(
    logic [8:0] d, logic nb, logic pe,
    logic po, logic ts, int b);
    frame_t f;
    int n;
    int ones;
    f.bits = '0;
    ones = 0;
    n = nb ? 9 : 8;
    f.bits[0] = 1'b0;
    f.nb = 1;
    for (int i = 0; i < n; i++) begin
      f.bits[f.nb] = d[i];
      ones += int'(d[i]);
      f.nb++;
    end
    if (pe) begin
      f.bits[f.nb] = ((ones % 2) == 1) ^ po;
      f.nb++;
    end
    f.bits[f.nb] = 1'b1;
    f.nb++;
    if (ts) begin
      f.bits[f.nb] = 1'b1;
      f.nb++;
    end
    f.bt = (b == 0) ? 1 : b;
    return f;
  endfunction

  // Monitor
  logic   cap[$];
  logic   in_frame = 1'b0;
  int     start_cyc = 0;
  int     done_cyc = 0;
  int     last_gap = 0;
  int     frames_done = 0;
  frame_t mf;
  int     mis;

  always @(negedge clk) begin
    if (reset) begin
      in_frame = 1'b0;
      cap.delete();
    end else begin
      if (fifo_read) begin
        chk("read_while_empty", int'(fifo_empty), 0);
      end
      if (!in_frame && tx === 1'b0) begin
        in_frame  = 1'b1;
        cap.delete();
        start_cyc = cyc;
        last_gap  = cyc - done_cyc;
      end
      if (in_frame) cap.push_back(tx);
      if (tx_done === 1'b1) begin
        if (!in_frame || expq.size() == 0) begin
          chk("unexpected_tx_done", 1, 0);
        end else begin
          mf = expq.pop_front();
          chk("frame_len", cap.size(), mf.nb * mf.bt);
          mis = -1;
          for (int i = 0; i < cap.size(); i++) begin
            if (mis < 0 && (i / mf.bt) < mf.nb &&
                cap[i] !== mf.bits[i / mf.bt]) begin
              mis = i;
            end
          end
          chk("frame_wave_bad_cycle", mis, -1);
        end
        in_frame = 1'b0;
        done_cyc = cyc;
        frames_done++;
      end
    end
  end

  task automatic set_cfg(logic nb, logic pe,
                         logic po, logic ts, int b);
    nine_bit   = nb;
    parity_en  = pe;
    parity_odd = po;
    two_stop   = ts;
    brd        = 16'(b);
  endtask

  task automatic push(logic [8:0] d);
    wmem[n_push % 256] = d;
    expq.push_back(mk(d, nine_bit, parity_en,
                      parity_odd, two_stop,
                      int'(brd)));
    n_push++;
  endtask

  task automatic wait_frames(int target, int budget);
    int t = 0;
    while (frames_done < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("frame_timeout", int'(frames_done >= target), 1);
  endtask

  int base;
  int c0;
  int t;
  int p;

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    set_cfg(0, 0, 0, 0, 1);
    repeat (2) @(negedge clk);
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fifo_read", int'(fifo_read), 0);
    chk("rst_tx_done", int'(tx_done), 0);
    reset = 1'b0;
    @(negedge clk);

    // 8N1, brd 4, 0x055
    set_cfg(0, 0, 0, 0, 4);
    enable = 1'b1;
    base = n_pop;
    c0 = cyc;
    push(9'h055);
    wait_frames(frames_done + 1, 300);
    chk("t1_pops", n_pop - base, 1);
    chk("t1_start_latency", start_cyc - c0, 3);

    // 8E1 then 8O1, 0x07, brd 2
    set_cfg(0, 1, 0, 0, 2);
    push(9'h007);
    wait_frames(frames_done + 1, 300);
    set_cfg(0, 1, 1, 0, 2);
    push(9'h007);
    wait_frames(frames_done + 1, 300);

    // 9-bit, 2 stop, brd 2, 0x1A5
    set_cfg(1, 0, 0, 1, 2);
    push(9'h1A5);
    wait_frames(frames_done + 1, 300);

    // Back-to-back, brd 1
    set_cfg(0, 0, 0, 0, 1);
    base = n_pop;
    push(9'($urandom));
    push(9'($urandom));
    wait_frames(frames_done + 2, 300);
    chk("b2b_pops", n_pop - base, 2);
    chk("b2b_gap", last_gap, 3);

    // Reset during DATA bit 3
    set_cfg(0, 0, 0, 0, 4);
    push(9'h0F3);
    t = 0;
    while (!in_frame && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rst_mid_start_seen", int'(in_frame), 1);
    repeat (17) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx", int'(tx), 1);
    chk("rst_mid_busy", int'(busy), 0);
    reset = 1'b0;
    if (expq.size() > 0) void'(expq.pop_front());
    base = n_pop;
    repeat (40) @(negedge clk);
    chk("rst_mid_no_read", n_pop - base, 0);
    chk("rst_mid_idle_busy", int'(busy), 0);

    // Empty FIFO with enable, then enable gating
    base = n_pop;
    repeat (30) @(negedge clk);
    chk("empty_no_read", n_pop - base, 0);
    enable = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    push(9'h0C9);
    repeat (20) @(negedge clk);
    chk("disabled_no_read", n_pop - base, 0);
    chk("disabled_busy", int'(busy), 0);
    enable = 1'b1;
    wait_frames(frames_done + 1, 300);

    // Randomized frames, config scrambled after LOAD
    for (int k = 0; k < 24; k++) begin
      set_cfg(1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom),
              int'($urandom_range(0, 5)));
      p = n_pop;
      push(9'($urandom));
      t = 0;
      while (n_pop == p && t < 100) begin
        @(negedge clk);
        t++;
      end
      repeat (2) @(negedge clk);
      set_cfg(1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom),
              int'($urandom_range(0, 5)));
      wait_frames(frames_done + 1, 400);
    end

    repeat (5) @(negedge clk);
    chk("end_idle_busy", int'(busy), 0);
    chk("end_exp_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
